// File: rtl/aes_block_uart_feeder_if.sv
// Block-input valid/ready bundle for the AES-to-UART feeder.
// The master presents a block; the slave (feeder) signals readiness.
interface aes_block_uart_feeder_if #(
    parameter int NBYTES = 16
);
    logic                  in_valid;
    logic [8*NBYTES-1:0]   in_block;
    logic                  in_ready;

    modport master (
        output in_valid,
        output in_block,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_block,
        output in_ready
    );
endinterface

// File: rtl/aes_block_uart_feeder.sv
// Serializes one AES block MSB-first into a byte-wide UART transmitter.
// Optional FEEDER_CRC_EN appends a CRC-8 (poly 0x07) byte to each block.
module aes_block_uart_feeder #(
    parameter int NBYTES      = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    aes_block_uart_feeder_if.slave  in_if,
    output logic                    tx_en,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    block_done,
    output logic                    err_timeout
);
    localparam int BW = 8 * NBYTES;
`ifdef FEEDER_CRC_EN
    localparam int NOUT = NBYTES + 1;
`else
    localparam int NOUT = NBYTES;
`endif
    localparam int CW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [CW-1:0] LAST    = CW'(NOUT - 1);
    localparam logic [7:0]    ACK_MAX = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACK,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [BW-1:0]   shreg_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      ack_q;
    logic [7:0]      ack_d;
    logic [7:0]      data_q;
    logic            start_q;
    logic            en_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

`ifdef FEEDER_CRC_EN
    logic [7:0]      crc_q;

    function automatic logic [7:0] crc8(input logic [7:0] c,
                                        input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`endif

    assign ack_d = ack_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef FEEDER_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            en_q   <= 1'b1;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_if.in_valid && ready_q) begin
                        shreg_q <= in_if.in_block;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef FEEDER_CRC_EN
                        crc_q   <= '0;
`endif
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_q <= 1'b1;
                    ack_q   <= '0;
                    state_q <= S_ACK;
`ifdef FEEDER_CRC_EN
                    // The slot after the last data byte carries the CRC.
                    if (cnt_q == CW'(NBYTES)) begin
                        data_q <= crc_q;
                    end else begin
                        data_q <= shreg_q[BW-1 -: 8];
                        crc_q  <= crc8(crc_q, shreg_q[BW-1 -: 8]);
                    end
`else
                    data_q <= shreg_q[BW-1 -: 8];
`endif
                end
                S_ACK: begin
                    ack_q <= ack_d;
                    if (tx_busy) begin
                        start_q <= 1'b0;
                        state_q <= S_DONE;
                    end else if (ack_d == ACK_MAX) begin
                        err_q   <= 1'b1;
                        start_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // Next start waits for S_LOAD so it never meets tx_done.
                    if (tx_done) begin
                        shreg_q <= shreg_q << 8;
                        if (cnt_q == LAST) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_if.in_ready = ready_q;
    assign tx_en          = en_q;
    assign tx_start       = start_q;
    assign tx_data        = data_q;
    assign busy           = busy_q;
    assign block_done     = done_q;
    assign err_timeout    = err_q;
endmodule

// File: tb/tb_aes_block_uart_feeder.sv
// Bench for aes_block_uart_feeder: vector table, random blocks,
// back-to-back, timeout and mid-block reset against a byte-list model.
module tb_aes_block_uart_feeder;
    localparam int NB = 16;
    localparam int AT = 15;
`ifdef FEEDER_CRC_EN
    localparam int NOUT = NB + 1;
`else
    localparam int NOUT = NB;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    aes_block_uart_feeder_if #(.NBYTES(NB)) bus ();

    logic       tx_en;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       busy;
    logic       block_done;
    logic       err_timeout;

    aes_block_uart_feeder #(.NBYTES(NB), .ACK_TIMEOUT(AT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (bus),
        .tx_en       (tx_en),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .busy        (busy),
        .block_done  (block_done),
        .err_timeout (err_timeout)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] got[$];
    logic [7:0] exp[$];

    // Transmitter model: busy after optional ack delay, done after 10 cycles.
    bit ack_en  = 1'b1;
    int ack_dly = 0;
    int wcnt    = 0;
    int ucnt    = 0;

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (tx_busy) begin
            if (ucnt == 9) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end else begin
                ucnt <= ucnt + 1;
            end
        end else if (tx_start && ack_en) begin
            if (wcnt >= ack_dly) begin
                tx_busy <= 1'b1;
                ucnt    <= 0;
                wcnt    <= 0;
                got.push_back(tx_data);
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    int overlap = 0, start_hi = 0, unstable = 0;
    int ndone = 0, done_nrdy = 0, nacc = 0, acc_w_done = 0, ntxdone = 0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) begin
        if (tx_start && tx_done) overlap <= overlap + 1;
        if (tx_start) start_hi <= start_hi + 1;
        if (tx_start && prev_start && tx_data != prev_data)
            unstable <= unstable + 1;
        prev_start <= tx_start;
        prev_data  <= tx_data;
        if (block_done) begin
            ndone <= ndone + 1;
            if (!bus.in_ready) done_nrdy <= done_nrdy + 1;
        end
        if (rst_n && bus.in_valid && bus.in_ready) begin
            nacc <= nacc + 1;
            if (block_done) acc_w_done <= acc_w_done + 1;
        end
        if (tx_done) ntxdone <= ntxdone + 1;
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_exp(input logic [127:0] b);
        logic [135:0] m;
        for (int i = 0; i < NB; i++) exp.push_back(b[127-8*i -: 8]);
`ifdef FEEDER_CRC_EN
        // CRC as polynomial remainder of (message * x^8) mod 0x107.
        m = {b, 8'h00};
        for (int i = 135; i >= 8; i--)
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        exp.push_back(m[7:0]);
`else
        m = '0;
`endif
    endtask

    task automatic cmp_bytes(input string tag);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.in_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", bus.in_ready, 1);
    endtask

    task automatic send(input logic [127:0] b);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_block = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("err_cleared_on_accept", err_timeout, 0);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_end(input string tag, input int d0);
        int k = 0;
        while (ndone == d0 && !err_timeout && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finish_in_time"}, k < 2000, 1);
    endtask

    typedef struct {
        logic [127:0] blk;
        bit           ack;
        bit           exp_err;
        int           exp_done;
    } vec_t;

    vec_t vt[8];
    int   d0, a0, aw0, t0, k;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_block = '0;

        vt[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 1'b0, 1};
        vt[1] = '{128'h0, 1'b1, 1'b0, 1};
        vt[2] = '{128'h1, 1'b1, 1'b0, 1};
        vt[3] = '{{4{$urandom}}, 1'b0, 1'b1, 0};
        vt[4] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1};
        vt[5] = '{{128{1'b1}}, 1'b1, 1'b0, 1};
        vt[6] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1};
        vt[7] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1};

        #1 rst_n = 1'b0;
        cyc(3);
        check("rst_tx_en_low", tx_en, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_tx_start", tx_start, 0);
        check("idle_busy", busy, 0);
        check("idle_tx_en", tx_en, 1);
        check("idle_err", err_timeout, 0);
        start_hi = 0;
        cyc(20);
        check("idle_no_start", start_hi, 0);

        for (int i = 0; i < 8; i++) begin
            got.delete();
            exp.delete();
            ack_en   = vt[i].ack;
            ack_dly  = $urandom_range(0, 3);
            d0       = ndone;
            start_hi = 0;
            if (vt[i].ack) add_exp(vt[i].blk);
            send(vt[i].blk);
            wait_end($sformatf("vec%0d", i), d0);
            cyc(3);
            cmp_bytes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), err_timeout, vt[i].exp_err);
            check($sformatf("vec%0d_done", i), ndone - d0, vt[i].exp_done);
            check($sformatf("vec%0d_ready", i), bus.in_ready, 1);
            check($sformatf("vec%0d_busy", i), busy, 0);
            if (!vt[i].ack)
                check($sformatf("vec%0d_start_cycles", i), start_hi, AT);
            if (i == 0 && got.size() >= NB) begin
                check("fips_first", got[0], 8'h69);
                check("fips_last", got[NB-1], 8'h5a);
            end
        end
        ack_en  = 1'b1;
        ack_dly = 0;

        // Back-to-back: in_valid held high across two blocks.
        got.delete();
        exp.delete();
        add_exp(vt[0].blk);
        add_exp(vt[4].blk);
        d0  = ndone;
        a0  = nacc;
        aw0 = acc_w_done;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_block = vt[0].blk;
        @(negedge clk);
        bus.in_block = vt[4].blk;
        k = 0;
        while (nacc - a0 < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b0;
        check("b2b_second_accept", nacc - a0, 2);
        check("b2b_accept_at_done", acc_w_done - aw0, 1);
        k = 0;
        while (ndone - d0 < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        cyc(3);
        check("b2b_dones", ndone - d0, 2);
        cmp_bytes("b2b");

        // Reset right after byte 5 completes.
        got.delete();
        exp.delete();
        t0 = ntxdone;
        send(vt[6].blk);
        k = 0;
        while (ntxdone - t0 < 6 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("mid_reach_byte5", ntxdone - t0, 6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_block_done", block_done, 0);
        check("mid_bytes_sent", got.size(), 6);
        cyc(3);
        rst_n = 1'b1;
        cyc(40);
        check("mid_no_more_bytes", got.size(), 6);
        got.delete();
        add_exp(vt[7].blk);
        d0 = ndone;
        send(vt[7].blk);
        wait_end("post_rst", d0);
        cyc(3);
        cmp_bytes("post_rst");
        check("post_rst_done", ndone - d0, 1);

        check("start_done_overlap", overlap, 0);
        check("tx_data_unstable", unstable, 0);
        check("done_without_ready", done_nrdy, 0);
        check("bytes_per_block", exp.size(), NOUT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
